bcd_digit_sanitize_ctrl: RTL
============================

// Module: bcd_digit_sanitize_ctrl
// PURPOSE
//   Sequencer that owns a digit-serial BCD validation datapath. Accepts a packed
//   NDIG-digit BCD word over a valid/ready handshake, then walks it LANES digits per
//   cycle. Each valid digit (0-9) is copied through; each invalid digit (A-F) is
//   replaced by 0 and counted. The result is presented over an output valid/ready
//   handshake. Sits between the BCD source and the decimal consumer.
// PARAMETERS
//   NDIG   300  digits per word; NDIG >= 1
//   LANES  1    digits checked per cycle; must divide NDIG (elaboration error otherwise)
//   CW     localparam = $clog2(NDIG+1); width of the invalid-digit count
// PORTS
//   clk           in   1        rising-edge clock
//   reset         in   1        synchronous, active-high reset
//   in_valid      in   1        source presents in_bcd
//   in_ready      out  1        block accepts a word (IDLE only)
//   in_bcd        in   4*NDIG   packed BCD; digit k = in_bcd[4k+3:4k]
//   out_valid     out  1        result available
//   out_ready     in   1        consumer takes the result
//   out_dec       out  4*NDIG   sanitized digits, same packing as in_bcd
//   out_bad_cnt   out  CW       number of invalid digits in the word
//   busy          out  1        high in RUN and DONE
// BEHAVIOUR
//   - Reset: state=IDLE; out_dec=0, out_bad_cnt=0, out_valid=0, busy=0, digit index=0.
//     in_ready=0 while reset is high. Reset mid-RUN/DONE discards the word; no output.
//   - FSM IDLE -> RUN -> DONE -> IDLE. in_ready = (state==IDLE) & !reset.
//   - IDLE: on in_valid&in_ready, register in_bcd in an internal source register;
//     clear out_dec, out_bad_cnt, idx; go to RUN. in_bcd may change afterwards.
//   - RUN: each cycle, for lanes j=0..LANES-1, with k=idx+j:
//     src digit k <= 9 -> out_dec digit k = src digit k; else out_dec digit k = 0.
//     out_bad_cnt += number of invalid lanes that cycle (0..LANES); never overflows
//     because CW holds NDIG. idx += LANES. On the beat where idx+LANES==NDIG, go to DONE.
//   - Latency: accept at edge E; RUN takes NDIG/LANES cycles; out_valid rises at
//     edge E+NDIG/LANES. Digits are written LSD first (digit 0 first).
//   - DONE: out_valid=1; out_dec/out_bad_cnt stable. On out_valid&out_ready go to
//     IDLE and drop out_valid. out_ready low means hold indefinitely.
//   - out_ready during IDLE/RUN is ignored. in_valid during RUN/DONE is ignored
//     (in_ready=0). No overlap of words.
//   - DONE->IDLE and a new acceptance cannot occur in the same cycle. The earliest
//     new acceptance is the cycle after the output handshake.
//   - out_dec/out_bad_cnt keep the last result in IDLE until the next acceptance.
//   - NDIG==LANES: RUN lasts exactly 1 cycle.
// CONFIGURATION
//   BCD_BAD_MASK_EN defined: adds output out_bad_mask [NDIG]. Bit k=1 iff digit k was
//     invalid. Same update timing and reset (0) as out_bad_cnt.
//     popcount(out_bad_mask)==out_bad_cnt holds in DONE.
//   Undefined: port absent; no mask storage. Behaviour otherwise identical.
// TESTING
//   1 NDIG=4,LANES=1: send 16'h9305 -> out_valid 4 cycles after accept,
//     out_dec=16'h9305, out_bad_cnt=0.
//   2 NDIG=4,LANES=1: send 16'hA3F9 -> out_dec=16'h0309, out_bad_cnt=2;
//     mask=4'b1010 with BCD_BAD_MASK_EN.
//   3 NDIG=4,LANES=2: send 16'hFFFF -> out_valid 2 cycles after accept, out_dec=0,
//     out_bad_cnt=4; in_ready=0 throughout RUN/DONE.
//   4 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_dec
//     stable; in_valid pulses ignored; release -> IDLE, next word accepted 1 cycle later.
//   5 Reset at RUN cycle 2 -> next cycle IDLE, all outputs 0; new word 16'h1234
//     -> out_dec=16'h1234, out_bad_cnt=0.
//   6 Default NDIG=300,LANES=1: all digits 4'hC -> out_valid at +300 cycles,
//     out_dec=0, out_bad_cnt=300.

Source files
------------

// File: rtl/bcd_digit_sanitize_ctrl.sv
// Digit-serial BCD sanitizer: walks a registered NDIG-digit word LANES digits per cycle,
// zeroing and counting digits A-F. Optional macro BCD_BAD_MASK_EN adds a per-digit bad mask.
module bcd_digit_sanitize_ctrl #(
  parameter int NDIG  = 300,
  parameter int LANES = 1,
  localparam int CW   = $clog2(NDIG + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_bcd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_dec,
  output logic [CW-1:0]     out_bad_cnt,
  output logic              busy
`ifdef BCD_BAD_MASK_EN
  ,
  output logic [NDIG-1:0]   out_bad_mask
`endif
);

  localparam int BW = (4 * NDIG > 1) ? $clog2(4 * NDIG) : 1;
  localparam int MW = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (NDIG < 1 || LANES < 1 || (NDIG % LANES) != 0) begin : g_bad_cfg
    $error("bcd_digit_sanitize_ctrl: LANES must be >= 1 and divide NDIG (NDIG >= 1)");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [4*NDIG-1:0] src_q, src_d;
  logic [4*NDIG-1:0] dec_q, dec_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [3:0]        digit;
  logic [BW-1:0]     bpos;
  logic [MW-1:0]     dpos;
`ifdef BCD_BAD_MASK_EN
  logic [NDIG-1:0]   mask_q, mask_d;
`endif

  assign in_ready    = (state_q == S_IDLE) & ~reset;
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign out_dec     = dec_q;
  assign out_bad_cnt = cnt_q;
`ifdef BCD_BAD_MASK_EN
  assign out_bad_mask = mask_q;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dec_d   = dec_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    digit   = '0;
    bpos    = '0;
    dpos    = '0;
`ifdef BCD_BAD_MASK_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Previous result stays visible until a new word is actually taken.
        if (in_valid && in_ready) begin
          src_d   = in_bcd;
          dec_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
`ifdef BCD_BAD_MASK_EN
          mask_d  = '0;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int j = 0; j < LANES; j++) begin
          bpos  = BW'(4 * (int'(idx_q) + j));
          dpos  = MW'(int'(idx_q) + j);
          digit = src_q[bpos +: 4];
          if (digit > 4'd9) begin
            dec_d[bpos +: 4] = 4'd0;
            cnt_d            = cnt_d + CW'(1);
`ifdef BCD_BAD_MASK_EN
            mask_d[dpos]     = 1'b1;
`endif
          end else begin
            dec_d[bpos +: 4] = digit;
          end
        end
        idx_d = idx_q + CW'(LANES);
        if (int'(idx_q) + LANES == NDIG) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dec_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
`ifdef BCD_BAD_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
`ifdef BCD_BAD_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

endmodule
